lsu_split_access: RTL
=====================

Name: lsu_split_access

Overview:
- Sequential load/store unit between the core's memory stage and the data-memory port. Generalises byte-lane steering and sign/zero extension to a DATA_W-wide bus.
- Owns the memory handshake. One outstanding request.
- Splits accesses that cross a word boundary into two memory beats and merges the result.
- Returns a sign- or zero-extended load result, or a fault, through a single-cycle response pulse.

Parameters:
DATA_W, 32, memory/register data width; legal values 32 or 64.
ADDR_W, 32, byte-address width.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  core request valid
req_ready  out  1  unit can accept a request; high only in IDLE
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V funct3 access size/sign
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, LSB-justified
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_W  extended load result; 0 for stores and faults
rsp_fault  out  1  valid with rsp_valid; illegal funct3, or misaligned access with the feature out
mem_req  out  1  memory request; held until granted
mem_gnt  in  1  memory accepted request this cycle
mem_we  out  1  write enable
mem_addr  out  ADDR_W  word-aligned address; low log2(DATA_W/8) bits are 0
mem_be  out  DATA_W/8  byte enables
mem_wdata  out  DATA_W  lane-shifted store data
mem_rvalid  in  1  read data valid, or write acknowledge; one per granted beat
mem_rdata  in  DATA_W  read data word

Behaviour:
- Reset state. Every output is 0 except req_ready, which is 1. FSM is in IDLE.
- Reset asserted mid-operation:
  - Abort immediately; mem_req drops asynchronously.
  - No response is issued.
  - A late mem_rvalid after reset release is ignored in IDLE.
- Definitions:
  - Word size WB = DATA_W/8.
  - Access size S: funct3 000/100 → 1; 001/101 → 2; 010/110 → 4; 011 → 8.
  - Legal funct3: 000, 001, 010, 100, 101; plus 011 and 110 only when DATA_W=64. 110 is illegal for stores.
  - off = addr mod WB.
  - Split needed when off+S > WB.
- FSM states: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP.
  - IDLE: a request is accepted when req_valid && req_ready; all fields are registered. Illegal funct3 → RESP with fault. Otherwise → ISSUE0.
  - ISSUE0/ISSUE1: mem_req=1 with stable addr/be/we/wdata until mem_gnt, then → WAIT0/WAIT1. mem_rvalid in an ISSUE state is ignored.
  - WAIT0: on mem_rvalid, capture rdata into beat-0 register; → ISSUE1 if split, else → RESP.
  - WAIT1: on mem_rvalid, capture beat 1; → RESP.
  - RESP: rsp_valid=1 for exactly one cycle; → IDLE. There is no response backpressure.
- Beat contents:
  - Beat 0: mem_addr = addr with low bits cleared.
  - Beat 0 be: ones on lanes off..min(off+S,WB)-1.
  - Beat 1: mem_addr = beat-0 address + WB, wrapping modulo 2^ADDR_W.
  - Beat 1 be: ones on lanes 0..(off+S-WB)-1.
  - Store data: req_wdata shifted left by 8*off across the concatenated {beat1,beat0} lanes.
- Load merge: {beat1,beat0} >> 8*off, truncated to S bytes.
  - Sign extension for 000/001/010 (010 only when DATA_W=64).
  - Zero extension for 100/101/110.
  - 011 passes through.
- Latency (aligned, mem_gnt same cycle as mem_req, mem_rvalid the next cycle):
  - Accept at T0, mem_req at T1, mem_rvalid at T2, rsp_valid at T3.
  - Split access adds 2 cycles.
  - Fault: rsp_valid at T1, and mem_req is never raised.

Optional Feature:
LSU_MISALIGNED_EN.
- Defined: split accesses behave as above.
- Undefined:
  - Any access with off mod S ≠ 0 goes IDLE → RESP with rsp_fault=1, rsp_rdata=0, and no memory beat.
  - ISSUE1/WAIT1 logic is not compiled.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU);
  - the lsu_state_e enum;
  - function access_bytes(funct3);
  - function funct3_legal(funct3, we, DATA_W).
- One natural sub-module, lsu_lane_align. It is purely combinational and produces:
  - beat-0/beat-1 byte enables;
  - the shifted write data;
  - the merged, extended load result from {beat1,beat0}, off and funct3.

Test Plan:
1. DATA_W=32: sw 0xDEADBEEF @0x100 → one beat, mem_addr=0x100, be=1111, rsp_valid at T3, fault=0.
2. lb @0x103, mem_rdata=0x80112233 → be=1000, rsp_rdata=0xFFFFFF80. lbu, same address and data → 0x00000080.
3. LSU_MISALIGNED_EN defined: lw @0x0FE, beat0 rdata=0xAABB0000, beat1 rdata=0x0000CCDD.
   - Beats: 0x0FC be=1100, then 0x100 be=0011.
   - Result: rsp_rdata=0xCCDDAABB, two cycles later than aligned.
4. Same lw, macro undefined → rsp_fault=1 at T1, mem_req never asserted. Also: funct3=011 at DATA_W=32 → fault.
5. mem_gnt held low 5 cycles → mem_req, mem_addr and mem_be stable throughout. rst_n pulsed low in WAIT0 → mem_req=0 and req_ready=1 immediately, no rsp_valid.
6. DATA_W=64: sd 0x0123456789ABCDEF @0x2004, split → beats 0x2000 be=0xF0 and 0x2008 be=0x0F, data lanes correct, single rsp_valid.

Source files
------------

// File: rtl/lsu_split_access_pkg.sv
// Shared LSU definitions: funct3 encodings, FSM state type, access-size and legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE0 = 3'd1,
    WAIT0  = 3'd2,
    ISSUE1 = 3'd3,
    WAIT1  = 3'd4,
    RESP   = 3'd5
  } lsu_state_e;

  // Access size in bytes for a funct3 encoding.
  function automatic logic [3:0] access_bytes(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: access_bytes = 4'd1;
      F3_H, F3_HU: access_bytes = 4'd2;
      F3_W, F3_WU: access_bytes = 4'd4;
      default:     access_bytes = 4'd8;
    endcase
  endfunction

  // Doubleword and unsigned-word accesses exist only on a 64-bit bus; lwu has no store form.
  function automatic logic funct3_legal(input logic [2:0] funct3, input logic we,
                                        input int unsigned data_w);
    case (funct3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: funct3_legal = 1'b1;
      F3_D:    funct3_legal = (data_w == 64);
      F3_WU:   funct3_legal = (data_w == 64) && !we;
      default: funct3_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_split_access_if.sv
// Core request/response and data-memory port bundle for the LSU.
interface lsu_split_access_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned WB = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_fault;
  logic              mem_req;
  logic              mem_gnt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WB-1:0]     mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_split_access_lane_align.sv
// Byte-lane steering across a two-beat window: byte enables, shifted store data, merged/extended load.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  localparam int unsigned WB    = DATA_W / 8,
  localparam int unsigned OFF_W = $clog2(WB)
) (
  input  logic [OFF_W-1:0]  i_off,
  input  logic [2:0]        i_funct3,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_beat0,
  input  logic [DATA_W-1:0] i_beat1,
  output logic [WB-1:0]     o_be0,
  output logic [WB-1:0]     o_be1,
  output logic [DATA_W-1:0] o_wdata0,
  output logic [DATA_W-1:0] o_wdata1,
  output logic [DATA_W-1:0] o_load
);
  logic [3:0]          w_size;
  logic [2*WB-1:0]     w_mask;
  logic [2*DATA_W-1:0] w_wshift;
  logic [DATA_W-1:0]   w_merged;

  assign w_size   = access_bytes(i_funct3);
  assign w_mask   = (((2*WB)'(1) << w_size) - (2*WB)'(1)) << i_off;
  assign w_wshift = {DATA_W'(0), i_wdata} << {i_off, 3'b000};
  assign w_merged = DATA_W'({i_beat1, i_beat0} >> {i_off, 3'b000});

  assign o_be0    = w_mask[WB-1:0];
  assign o_be1    = w_mask[2*WB-1:WB];
  assign o_wdata0 = w_wshift[DATA_W-1:0];
  assign o_wdata1 = w_wshift[2*DATA_W-1:DATA_W];

  always_comb begin
    o_load = w_merged;
    case (i_funct3)
      F3_B:    o_load = DATA_W'($signed(w_merged[7:0]));
      F3_H:    o_load = DATA_W'($signed(w_merged[15:0]));
      F3_W:    o_load = DATA_W'($signed(w_merged[31:0]));
      F3_BU:   o_load = DATA_W'(w_merged[7:0]);
      F3_HU:   o_load = DATA_W'(w_merged[15:0]);
      F3_WU:   o_load = DATA_W'(w_merged[31:0]);
      default: o_load = w_merged;
    endcase
  end
endmodule

// File: rtl/lsu_split_access.sv
// Sequential LSU owning the data-memory handshake; one outstanding request.
// LSU_MISALIGNED_EN: split word-crossing accesses into two beats; otherwise misaligned accesses fault.
module lsu_split_access
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input logic              clk,
  input logic              rst_n,
  lsu_split_access_if.slave bus
);
  localparam int unsigned WB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(WB);

  lsu_state_e        r_state;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [OFF_W-1:0]  r_off;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_beat0;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_fault;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [WB-1:0]     r_mem_be;
  logic [DATA_W-1:0] r_mem_wdata;

  logic              w_idle;
  logic [OFF_W-1:0]  w_in_off;
  logic [3:0]        w_size;
  logic              w_legal;
  logic [ADDR_W-1:0] w_base_in;
  logic [OFF_W-1:0]  w_off;
  logic [2:0]        w_funct3;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_beat0;
  logic [DATA_W-1:0] w_beat1;
  logic [WB-1:0]     w_be0;
  logic [WB-1:0]     w_be1;
  logic [DATA_W-1:0] w_wdata0;
  logic [DATA_W-1:0] w_wdata1;
  logic [DATA_W-1:0] w_load;
  logic              w_reject;

  assign w_idle    = (r_state == IDLE);
  assign w_in_off  = bus.req_addr[OFF_W-1:0];
  assign w_size    = access_bytes(bus.req_funct3);
  assign w_legal   = funct3_legal(bus.req_funct3, bus.req_we, DATA_W);
  assign w_base_in = {bus.req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};

  // The aligner sees the incoming request in IDLE and the captured one afterwards.
  assign w_off    = w_idle ? w_in_off : r_off;
  assign w_funct3 = w_idle ? bus.req_funct3 : r_funct3;
  assign w_wdata  = w_idle ? bus.req_wdata : r_wdata;
  assign w_beat0  = (r_state == WAIT0) ? bus.mem_rdata : r_beat0;

`ifdef LSU_MISALIGNED_EN
  logic [ADDR_W-1:0] r_base;
  logic [DATA_W-1:0] r_beat1;
  logic              r_split;
  logic              w_split_in;

  assign w_split_in = (5'(w_in_off) + 5'(w_size)) > 5'(WB);
  assign w_beat1    = (r_state == WAIT1) ? bus.mem_rdata : r_beat1;
  assign w_reject   = !w_legal;
`else
  logic w_misal;
  logic w_unused;

  assign w_misal  = (4'(w_in_off) & (w_size - 4'd1)) != 4'd0;
  assign w_beat1  = '0;
  assign w_reject = !w_legal || w_misal;
  assign w_unused = ^{w_be1, w_wdata1};
`endif

  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .i_off    (w_off),
    .i_funct3 (w_funct3),
    .i_wdata  (w_wdata),
    .i_beat0  (w_beat0),
    .i_beat1  (w_beat1),
    .o_be0    (w_be0),
    .o_be1    (w_be1),
    .o_wdata0 (w_wdata0),
    .o_wdata1 (w_wdata1),
    .o_load   (w_load)
  );

  // Control FSM; every output is registered and updated alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_funct3    <= '0;
      r_off       <= '0;
      r_wdata     <= '0;
      r_beat0     <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_fault <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
`ifdef LSU_MISALIGNED_EN
      r_base      <= '0;
      r_beat1     <= '0;
      r_split     <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid && r_req_ready) begin
            r_we        <= bus.req_we;
            r_funct3    <= bus.req_funct3;
            r_off       <= w_in_off;
            r_wdata     <= bus.req_wdata;
            r_req_ready <= 1'b0;
`ifdef LSU_MISALIGNED_EN
            r_base      <= w_base_in;
            r_split     <= w_split_in;
`endif
            if (w_reject) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_fault <= 1'b1;
              r_rsp_rdata <= '0;
            end else begin
              r_state     <= ISSUE0;
              r_mem_req   <= 1'b1;
              r_mem_we    <= bus.req_we;
              r_mem_addr  <= w_base_in;
              r_mem_be    <= w_be0;
              r_mem_wdata <= w_wdata0;
            end
          end
        end
        ISSUE0: begin
          if (bus.mem_gnt) begin
            r_state     <= WAIT0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
          end
        end
        WAIT0: begin
          if (bus.mem_rvalid) begin
            r_beat0 <= bus.mem_rdata;
`ifdef LSU_MISALIGNED_EN
            if (r_split) begin
              r_state     <= ISSUE1;
              r_mem_req   <= 1'b1;
              r_mem_we    <= r_we;
              r_mem_addr  <= r_base + ADDR_W'(WB);
              r_mem_be    <= w_be1;
              r_mem_wdata <= w_wdata1;
            end else
`endif
            begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_fault <= 1'b0;
              r_rsp_rdata <= r_we ? '0 : w_load;
            end
          end
        end
`ifdef LSU_MISALIGNED_EN
        ISSUE1: begin
          if (bus.mem_gnt) begin
            r_state     <= WAIT1;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
          end
        end
        WAIT1: begin
          if (bus.mem_rvalid) begin
            r_beat1     <= bus.mem_rdata;
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_fault <= 1'b0;
            r_rsp_rdata <= r_we ? '0 : w_load;
          end
        end
`endif
        RESP: begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
          r_rsp_fault <= 1'b0;
          r_rsp_rdata <= '0;
          r_req_ready <= 1'b1;
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_fault = r_rsp_fault;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_be    = r_mem_be;
  assign bus.mem_wdata = r_mem_wdata;
endmodule
